// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: the RAM word, the RAM port
// status, and the arbiter ownership states.
package mem_req_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_timeout_counter.sv
// Counts the cycles an owned request has waited for ACCESS; expired flags
// the last cycle the arbiter may wait before it declares a timeout.
module mem_req_arbiter_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic sRST,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturate at the limit; the arbiter leaves the request state on expiry anyway.
  always_ff @(posedge CLK) begin
    if (sRST || clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency RAM port,
// returning a one-cycle hit to the owner and a busy indication for hazards.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              sRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output word_t             iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output word_t             dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate,
  output logic              rambusy,
  output logic              timeout_err
);

  arb_state_t state;
  arb_state_t next_state;
  logic       in_req;
  logic       owner_req;
  logic       access;
  logic       expired;
  logic       err_flag;

  assign in_req    = (state == IREQ) || (state == DREQ);
  assign owner_req = (state == DREQ) ? (dREN || dWEN) : iREN;
  assign access    = (ramstate == ACCESS);

  mem_req_arbiter_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .sRST    (sRST),
    .clear   (!in_req),
    .inc     (in_req && !access),
    .expired (expired)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (sRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (sRST) begin
      err_flag <= 1'b0;
    end else if (next_state == ERR) begin
      err_flag <= 1'b1;
    end
  end

  // Next state: data wins in IDLE, the owner is never preempted, and ACCESS
  // beats both a request drop and the timeout limit in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dREN || dWEN) begin
          next_state = DREQ;
        end else if (iREN) begin
          next_state = IREQ;
        end
      end
      IREQ, DREQ: begin
        if (access) begin
          next_state = IDLE;
        end else if (ramstate == ERROR) begin
          next_state = ERR;
        end else if (!owner_req) begin
          next_state = IDLE;
        end else if (expired) begin
          next_state = ERR;
        end
      end
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: everything except the load buses is held low while in reset so
  // an abandoned transaction cannot hit.
  always_comb begin
    iload       = ramload;
    dload       = ramload;
    ihit        = 1'b0;
    dhit        = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    rambusy     = 1'b0;
    timeout_err = err_flag && !sRST;
    if (!sRST) begin
      case (state)
        IDLE: begin
          rambusy = iREN || dREN || dWEN;
        end
        IREQ: begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          ihit    = access;
          rambusy = !access;
        end
        DREQ: begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN && !dWEN;
          dhit     = access;
          rambusy  = !access;
        end
        ERR: begin
          rambusy = 1'b1;
        end
        default: begin
          rambusy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized checks of mem_req_arbiter against a behavioural
// ownership model of the arbitration rules.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned AW = 32;

  logic          CLK;
  logic          sRST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  word_t         iload;
  logic          ihit;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  word_t         dstore;
  word_t         dload;
  logic          dhit;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  word_t         ramstore;
  word_t         ramload;
  ramstate_t     ramstate;
  logic          rambusy;
  logic          timeout_err;

  mem_req_arbiter #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .CLK(CLK), .sRST(sRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .rambusy(rambusy), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), how long the
  // owner has waited without ACCESS, and whether the arbiter is dead.
  int m_own  = 0;
  int m_wait = 0;
  bit m_dead = 1'b0;

  // Last sampled outputs and hit tallies for directed checks
  logic  s_ihit, s_dhit, s_ren, s_wen, s_busy, s_terr;
  word_t s_iload, s_dload, s_store;
  logic [AW-1:0] s_addr;
  int    ihit_cnt = 0;
  int    dhit_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    bit e_ren, e_wen, e_ihit, e_dhit, e_busy, e_terr, acc, oreq;
    @(negedge CLK);
    e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0; e_busy = 0; e_terr = 0;
    acc = (ramstate == ACCESS);
    if (sRST) begin
      chk("rst_ramaddr", 32'(ramaddr), 32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
    end else if (m_dead) begin
      e_busy = 1; e_terr = 1;
    end else if (m_own == 0) begin
      e_busy = iREN | dREN | dWEN;
    end else if (m_own == 2) begin
      chk("d_ramaddr", 32'(ramaddr), 32'(daddr));
      chk("d_ramstore", ramstore, dstore);
      e_wen = dWEN; e_ren = dREN & ~dWEN; e_dhit = acc; e_busy = ~acc;
    end else begin
      chk("i_ramaddr", 32'(ramaddr), 32'(iaddr));
      e_ren = 1; e_ihit = acc; e_busy = ~acc;
    end
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("ihit", 32'(ihit), 32'(e_ihit));
    chk("dhit", 32'(dhit), 32'(e_dhit));
    chk("rambusy", 32'(rambusy), 32'(e_busy));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    s_ihit = ihit; s_dhit = dhit; s_ren = ramREN; s_wen = ramWEN;
    s_busy = rambusy; s_terr = timeout_err; s_iload = iload; s_dload = dload;
    s_store = ramstore; s_addr = ramaddr;
    if (ihit === 1'b1) ihit_cnt++;
    if (dhit === 1'b1) dhit_cnt++;
    @(posedge CLK);
    #1;
    if (sRST) begin
      m_own = 0; m_wait = 0; m_dead = 0;
    end else if (!m_dead) begin
      if (m_own == 0) begin
        m_wait = 0;
        if (dREN | dWEN) m_own = 2;
        else if (iREN) m_own = 1;
      end else begin
        oreq = (m_own == 2) ? (dREN | dWEN) : iREN;
        if (acc) m_own = 0;
        else if (ramstate == ERROR) m_dead = 1;
        else if (!oreq) m_own = 0;
        else if (m_wait == int'(TO) - 1) m_dead = 1;
        else m_wait++;
      end
    end
  endtask

  initial begin
    int h0;
    sRST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h1234_5678; ramstate = FREE;

    // Reset
    cyc(); cyc();
    chk("rst_busy", 32'(s_busy), 32'h0);
    chk("rst_iload_passthru", s_iload, 32'h1234_5678);
    sRST = 0;
    cyc();

    // Fetch with two BUSY cycles before ACCESS
    h0 = ihit_cnt;
    iREN = 1; iaddr = 32'h40;
    cyc();
    ramstate = BUSY; cyc();
    chk("t1_ramaddr", 32'(s_addr), 32'h40);
    cyc();
    chk("t1_ramREN", 32'(s_ren), 32'h1);
    ramstate = ACCESS; ramload = 32'h8C01_0004; cyc();
    chk("t1_iload", s_iload, 32'h8C01_0004);
    iREN = 0; ramstate = FREE; cyc();
    chk("t1_ihit_pulses", 32'(ihit_cnt - h0), 32'h1);

    // Simultaneous requests: data first, one IDLE gap, then fetch
    iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h44;
    cyc();
    ramstate = ACCESS; ramload = 32'hAAAA_0001; cyc();
    chk("t2_dhit_first", 32'(s_dhit), 32'h1);
    chk("t2_no_ihit", 32'(s_ihit), 32'h0);
    dREN = 0; ramstate = FREE; cyc();
    chk("t2_gap_no_ren", 32'(s_ren), 32'h0);
    ramstate = ACCESS; ramload = 32'hBBBB_0002; cyc();
    chk("t2_ihit_after_gap", 32'(s_ihit), 32'h1);
    iREN = 0; ramstate = FREE; cyc();

    // Write hits on the first owned cycle
    dWEN = 1; dstore = 32'hDEAD_BEEF; daddr = 32'h200; ramstate = ACCESS;
    cyc();
    chk("t3_no_hit_arb_cycle", 32'(s_dhit), 32'h0);
    cyc();
    chk("t3_dhit", 32'(s_dhit), 32'h1);
    chk("t3_ramWEN", 32'(s_wen), 32'h1);
    chk("t3_ramREN", 32'(s_ren), 32'h0);
    chk("t3_ramstore", s_store, 32'hDEAD_BEEF);
    dWEN = 0; ramstate = FREE; cyc();

    // Data flush while BUSY, pending fetch then granted
    h0 = dhit_cnt;
    dREN = 1; iREN = 1; daddr = 32'h300; iaddr = 32'h48; ramstate = BUSY;
    cyc(); cyc();
    dREN = 0; cyc();
    cyc();
    chk("t4_idle_busy", 32'(s_busy), 32'h1);
    chk("t4_idle_no_ren", 32'(s_ren), 32'h0);
    ramstate = ACCESS; cyc();
    chk("t4_ihit", 32'(s_ihit), 32'h1);
    chk("t4_no_dhit", 32'(dhit_cnt - h0), 32'h0);
    iREN = 0; ramstate = FREE; cyc();

    // Timeout into ERR, recovered only by reset
    dREN = 1; daddr = 32'h400; ramstate = BUSY;
    cyc();
    for (int i = 0; i < int'(TO); i++) cyc();
    cyc();
    chk("t5_timeout_err", 32'(s_terr), 32'h1);
    chk("t5_strobes", 32'({s_ren, s_wen}), 32'h0);
    dREN = 0; ramstate = ACCESS; cyc();
    chk("t5_err_no_hit", 32'(s_dhit), 32'h0);
    sRST = 1; ramstate = FREE; cyc();
    sRST = 0; cyc();
    chk("t5_err_cleared", 32'(s_terr), 32'h0);

    // Reset during ACCESS abandons the fetch
    iREN = 1; iaddr = 32'h50; cyc();
    ramstate = BUSY; cyc();
    sRST = 1; ramstate = ACCESS; cyc();
    chk("t6_ihit_in_rst", 32'(s_ihit), 32'h0);
    sRST = 0; iREN = 0; ramstate = FREE; cyc();
    chk("t6_busy_after", 32'(s_busy), 32'h0);
    chk("t6_ren_after", 32'(s_ren), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r;
      sRST = ($urandom_range(0, 59) == 0) || (m_dead && $urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 99));
      ramstate = (r < 2) ? ERROR : (r < 37) ? ACCESS : (r < 75) ? BUSY : FREE;
      if ($urandom_range(0, 4) == 0) iREN = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        dREN = 1'($urandom);
        dWEN = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) iaddr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) daddr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) dstore = $urandom;
      ramload = $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
